fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the 16-bit pipelined core. It owns the PC and the IF/ID pipeline register, and drives the instruction-memory request handshake. It sits directly upstream of the jump predictor: it takes the predictor's ID-stage prediction and its MEM-stage miss/correction signals, and selects the next PC. It also issues the squash signals for younger pipeline stages and keeps saturating prediction counters.

## Interface
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: hazard unit holds IF/ID and PC.
- `halt` in 1: halt instruction reached MEM.
- `jump_pred` in 1: predictor redirects to `jump_pred_adr` (ID stage).
- `jump_pred_adr` in 16: predicted target.
- `jump_pred_miss` in 1: predicted taken, actually not taken; correct to `pcinc_evac`.
- `jump_pred_adr_miss` in 1: taken, but wrong or no prediction; correct to `ALUres_mem`.
- `pcinc_evac` in 16: fall-through address of the mispredicted branch.
- `ALUres_mem` in 16: resolved jump target.
- `imem_ready` in 1: instruction memory returns data this cycle.
- `imem_rdata` in 16: instruction word.
- `imem_req` out 1: fetch request.
- `imem_adr` out 16: fetch address, equal to the PC register.
- `instr_if` out 16: IF/ID instruction.
- `pcinc_if` out 16: IF/ID PC+1.
- `valid_if` out 1: IF/ID holds a live instruction.
- `flush_id` out 1: squash ID/EX register.
- `flush_ex` out 1: squash EX/MEM register.
- `pred_cnt` out 16: count of predictions taken, saturating.
- `miss_cnt` out 16: count of corrections, saturating.

## Operation
- States: `FETCH`, `DISCARD`, `HALTED`.
- **Correction** (`jump_pred_miss | jump_pred_adr_miss`):
  - Target is `ALUres_mem` if `jump_pred_adr_miss`, else `pcinc_evac`. `adr_miss` wins if both are asserted.
  - `flush_id` and `flush_ex` are driven combinationally high in the same cycle.
  - Next edge: `valid_if <= 0`.
- **Prediction** (`jump_pred`, no correction):
  - Target is `jump_pred_adr`.
  - The sequential instruction in flight is dropped: `valid_if <= 0`.
  - No flush outputs.
- **Redirect priority:** reset > correction > halt > stall > prediction > sequential. `stall` is ignored during a correction; prediction is ignored during a stall.
- **`FETCH`:**
  - `imem_req = !stall` unless a request is outstanding. An outstanding request (`req & !ready` last cycle) keeps `req` high, and `imem_adr` stays stable until `ready`.
  - On `req & ready` without redirect: `instr_if <= imem_rdata`, `pcinc_if <= pc+1`, `valid_if <= 1`, `pc <= pc+1`.
  - PC arithmetic is modulo 2^16: 16'hFFFF+1 = 16'h0000.
- **Redirect while a request is outstanding (`req & !ready`):** store the target in the pending register and go to `DISCARD`.
- **`DISCARD`:**
  - `req` stays high at the old address and returning data is discarded.
  - On `ready`: `pc <= pending`, go to `FETCH`.
  - A newer correction in `DISCARD` overwrites `pending`.
- **Redirect with no outstanding request:** `pc <= target` directly, stay in `FETCH`.
- **Stall:**
  - IF/ID, `pc` and `valid_if` hold.
  - A fetch completing under stall is captured in a one-entry hold buffer and moved to IF/ID on the first non-stall cycle. No new request is issued while the buffer is full.
  - A correction empties the buffer.
- **`halt`:** go to `HALTED` with `imem_req = 0` and `valid_if <= 0`. `HALTED` is left only by reset; an outstanding request is abandoned.
- **Counters:**
  - `pred_cnt` increments on `jump_pred` accepted.
  - `miss_cnt` increments on any correction.
  - Both saturate at 16'hFFFF.

## Timing
- **Reset values:**
  - `pc`/`imem_adr` = `RESET_PC`.
  - `imem_req` = 0 during the reset cycle and 1 in the first cycle after.
  - `instr_if`, `pcinc_if`, `valid_if` = 0; `flush_id`, `flush_ex` = 0.
  - Counters = 0, state `FETCH`, hold buffer empty.
  - Reset mid-`DISCARD` or mid-stall returns everything to these values.
- Fetch latency: `req` to IF/ID valid is 1 edge after `ready`. Zero-wait memory gives one instruction per cycle.
- Correction penalty: 3 squashed slots. IF/ID, ID/EX and EX/MEM are bubbles at the next edge; the target is fetched in the cycle after the correction.
- Prediction penalty: 1 bubble.
- Flush outputs are purely combinational from the miss inputs and are never registered.

## Structure
- Shared package `core_pkg`: `WORD_W = 16`, enum `fetch_state_t {FETCH, DISCARD, HALTED}`, and the redirect-source enum `redir_t {NONE, PRED, CORR_ADR, CORR_FALL}`.
- One sub-module: `sat_cnt16` (enable, synchronous reset, saturating), instantiated twice.

## Test plan
- Reset with `RESET_PC` = 16'h0010, `ready` tied 1 → `imem_adr` 0010, 0011, 0012 on successive cycles; `pcinc_if` = 0011 with `valid_if` = 1 one edge after the first fetch.
- `jump_pred` = 1 with `jump_pred_adr` = 16'h0040 → next `imem_adr` = 0040, one `valid_if` = 0 bubble, `pred_cnt` = 1.
- `jump_pred_adr_miss` with `ALUres_mem` = 16'h0123, `jump_pred` also high → `flush_id` = `flush_ex` = 1 that cycle, next `imem_adr` = 0123, `miss_cnt` = 1; `jump_pred_miss` with `pcinc_evac` = 16'h0051 → `imem_adr` = 0051.
- `ready` low 3 cycles, correction to 16'h0200 in the second → `imem_adr` held until `ready`, data discarded, then `imem_adr` = 0200; `valid_if` never shows the stale word.
- PC at 16'hFFFF → next `imem_adr` = 16'h0000; `stall` for 2 cycles during a completing fetch → word delivered from the hold buffer on release, with no duplicate and no loss.
- `halt` pulse → `imem_req` = 0 permanently, `valid_if` = 0; only `reset` restarts fetch at `RESET_PC`.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and helpers for the 16-bit pipelined core front end.
package core_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    FETCH,
    DISCARD,
    HALTED
  } fetch_state_t;

  typedef enum logic [1:0] {
    NONE,
    PRED,
    CORR_ADR,
    CORR_FALL
  } redir_t;

  // IF/ID payload: fetched word and the address following it.
  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pcinc;
  } ifid_t;

  // Sequential PC step; wraps modulo 2^WORD_W.
  function automatic logic [WORD_W-1:0] pc_inc(input logic [WORD_W-1:0] pc);
    return pc + WORD_W'(1);
  endfunction

endpackage

// File: rtl/sat_cnt16.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_cnt16
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic [WORD_W-1:0] cnt
);

  localparam logic [WORD_W-1:0] CNT_MAX = '1;

  // Count enabled events until saturation.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (en && (cnt != CNT_MAX)) begin
      cnt <= cnt + WORD_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, IF/ID register, imem handshake, redirects and squash.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              halt,
  input  logic              jump_pred,
  input  logic [WORD_W-1:0] jump_pred_adr,
  input  logic              jump_pred_miss,
  input  logic              jump_pred_adr_miss,
  input  logic [WORD_W-1:0] pcinc_evac,
  input  logic [WORD_W-1:0] ALUres_mem,
  input  logic              imem_ready,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_adr,
  output logic [WORD_W-1:0] instr_if,
  output logic [WORD_W-1:0] pcinc_if,
  output logic              valid_if,
  output logic              flush_id,
  output logic              flush_ex,
  output logic [WORD_W-1:0] pred_cnt,
  output logic [WORD_W-1:0] miss_cnt
);

  fetch_state_t      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] pend_q, pend_d;
  ifid_t             ifid_q, ifid_d;
  logic              valid_q, valid_d;
  ifid_t             hold_q, hold_d;
  logic              hold_v_q, hold_v_d;
  logic              busy_q, busy_d;

  logic              corr;
  redir_t            redir;
  logic [WORD_W-1:0] target;
  logic              req_c;
  logic              fire;
  ifid_t             fetched;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      pend_q   <= '0;
      ifid_q   <= '0;
      valid_q  <= 1'b0;
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pend_q   <= pend_d;
      ifid_q   <= ifid_d;
      valid_q  <= valid_d;
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
      busy_q   <= busy_d;
    end
  end

  // Redirect selection, request generation and next-state logic.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pend_d   = pend_q;
    ifid_d   = ifid_q;
    valid_d  = valid_q;
    hold_d   = hold_q;
    hold_v_d = hold_v_q;
    redir    = NONE;
    target   = pc_q;
    req_c    = 1'b0;

    corr     = jump_pred_miss | jump_pred_adr_miss;
    flush_id = corr;
    flush_ex = corr;

    // Correction beats halt and stall; prediction only in a free-running FETCH.
    if (jump_pred_adr_miss) begin
      redir = CORR_ADR;
    end else if (jump_pred_miss) begin
      redir = CORR_FALL;
    end else if ((state_q == FETCH) && !halt && !stall && jump_pred) begin
      redir = PRED;
    end

    case (redir)
      CORR_ADR:  target = ALUres_mem;
      CORR_FALL: target = pcinc_evac;
      PRED:      target = jump_pred_adr;
      default:   target = pc_q;
    endcase

    // An outstanding request must stay up; a full hold buffer blocks new ones.
    case (state_q)
      FETCH:   req_c = busy_q | (!(stall && !corr) && !hold_v_q);
      DISCARD: req_c = 1'b1;
      default: req_c = 1'b0;
    endcase
    if (reset || (halt && !corr)) begin
      req_c = 1'b0;
    end

    fire          = req_c & imem_ready;
    busy_d        = req_c & ~imem_ready;
    fetched.instr = imem_rdata;
    fetched.pcinc = pc_inc(pc_q);

    case (state_q)
      FETCH: begin
        if (redir != NONE) begin
          valid_d  = 1'b0;
          hold_v_d = 1'b0;
          if (req_c && !imem_ready) begin
            pend_d  = target;
            state_d = DISCARD;
          end else begin
            pc_d = target;
          end
        end else if (halt) begin
          valid_d = 1'b0;
          state_d = HALTED;
        end else if (stall) begin
          if (fire) begin
            hold_d   = fetched;
            hold_v_d = 1'b1;
            pc_d     = pc_inc(pc_q);
          end
        end else if (hold_v_q) begin
          ifid_d   = hold_q;
          valid_d  = 1'b1;
          hold_v_d = 1'b0;
        end else if (fire) begin
          ifid_d  = fetched;
          valid_d = 1'b1;
          pc_d    = pc_inc(pc_q);
        end else begin
          valid_d = 1'b0;
        end
      end

      DISCARD: begin
        if (halt && !corr) begin
          valid_d = 1'b0;
          state_d = HALTED;
        end else begin
          if (corr || !stall) begin
            valid_d = 1'b0;
          end
          if (imem_ready) begin
            pc_d    = corr ? target : pend_q;
            state_d = FETCH;
          end else if (corr) begin
            pend_d = target;
          end
        end
      end

      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  assign imem_req = req_c;
  assign imem_adr = pc_q;
  assign instr_if = ifid_q.instr;
  assign pcinc_if = ifid_q.pcinc;
  assign valid_if = valid_q;

  sat_cnt16 u_pred_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (redir == PRED),
    .cnt   (pred_cnt)
  );

  sat_cnt16 u_miss_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (corr),
    .cnt   (miss_cnt)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus random bench for fetch_unit against a behavioural front-end model.
module tb_fetch_unit;

  localparam logic [15:0] RST_PC = 16'h0010;
  localparam int M_RUN   = 0;
  localparam int M_DRAIN = 1;
  localparam int M_HALT  = 2;

  logic        clk = 1'b0;
  logic        reset, stall, halt, jump_pred, jump_pred_miss, jump_pred_adr_miss;
  logic [15:0] jump_pred_adr, pcinc_evac, ALUres_mem, imem_rdata;
  logic        imem_ready;
  logic        imem_req, valid_if, flush_id, flush_ex;
  logic [15:0] imem_adr, instr_if, pcinc_if, pred_cnt, miss_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Model of the front end: fetch address, redirect bookkeeping, IF/ID, buffer.
  int          m_mode;
  bit          m_known = 1'b0;
  bit          m_busy;
  bit          m_valid;
  logic [15:0] m_pc, m_pend, m_instr, m_pcinc;
  logic [31:0] m_hq[$];
  int unsigned m_pcnt, m_mcnt;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk                (clk),
    .reset              (reset),
    .stall              (stall),
    .halt               (halt),
    .jump_pred          (jump_pred),
    .jump_pred_adr      (jump_pred_adr),
    .jump_pred_miss     (jump_pred_miss),
    .jump_pred_adr_miss (jump_pred_adr_miss),
    .pcinc_evac         (pcinc_evac),
    .ALUres_mem         (ALUres_mem),
    .imem_ready         (imem_ready),
    .imem_rdata         (imem_rdata),
    .imem_req           (imem_req),
    .imem_adr           (imem_adr),
    .instr_if           (instr_if),
    .pcinc_if           (pcinc_if),
    .valid_if           (valid_if),
    .flush_id           (flush_id),
    .flush_ex           (flush_ex),
    .pred_cnt           (pred_cnt),
    .miss_cnt           (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Whether the fetch stage should be asking memory for a word right now.
  function automatic bit model_req();
    bit c;
    c = jump_pred_miss | jump_pred_adr_miss;
    if (reset) return 1'b0;
    if (halt && !c) return 1'b0;
    if (m_mode == M_HALT) return 1'b0;
    if (m_mode == M_DRAIN) return 1'b1;
    if (m_busy) return 1'b1;
    if (m_hq.size() != 0) return 1'b0;
    return !stall || c;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_update(input bit rq);
    bit          c, p, got;
    logic [15:0] tgt;
    if (reset) begin
      m_known = 1'b1;
      m_mode  = M_RUN;
      m_pc    = RST_PC;
      m_pend  = 16'h0;
      m_instr = 16'h0;
      m_pcinc = 16'h0;
      m_valid = 1'b0;
      m_busy  = 1'b0;
      m_hq.delete();
      m_pcnt  = 0;
      m_mcnt  = 0;
      return;
    end
    c   = jump_pred_miss | jump_pred_adr_miss;
    got = rq && imem_ready;
    tgt = jump_pred_adr_miss ? ALUres_mem : pcinc_evac;
    if (c && m_mcnt < 65535) m_mcnt++;
    if (m_mode == M_HALT) begin
      m_valid = 1'b0;
    end else if (m_mode == M_DRAIN) begin
      if (halt && !c) begin
        m_mode  = M_HALT;
        m_valid = 1'b0;
      end else begin
        if (c || !stall) m_valid = 1'b0;
        if (imem_ready) begin
          m_pc   = c ? tgt : m_pend;
          m_mode = M_RUN;
        end else if (c) begin
          m_pend = tgt;
        end
      end
    end else begin
      p = jump_pred && !c && !halt && !stall;
      if (p) tgt = jump_pred_adr;
      if (c || p) begin
        if (p && m_pcnt < 65535) m_pcnt++;
        m_valid = 1'b0;
        m_hq.delete();
        if (rq && !imem_ready) begin
          m_pend = tgt;
          m_mode = M_DRAIN;
        end else begin
          m_pc = tgt;
        end
      end else if (halt) begin
        m_mode  = M_HALT;
        m_valid = 1'b0;
      end else if (stall) begin
        if (got) begin
          m_hq.push_back({imem_rdata, m_pc + 16'd1});
          m_pc = m_pc + 16'd1;
        end
      end else if (m_hq.size() != 0) begin
        {m_instr, m_pcinc} = m_hq.pop_front();
        m_valid = 1'b1;
      end else if (got) begin
        m_instr = imem_rdata;
        m_pcinc = m_pc + 16'd1;
        m_valid = 1'b1;
        m_pc    = m_pc + 16'd1;
      end else begin
        m_valid = 1'b0;
      end
    end
    m_busy = rq && !imem_ready;
  endtask

  // One clock: drive, check combinational outputs, clock, check registers.
  task automatic step(input bit rs, input bit st, input bit hl, input bit jp,
                      input bit jm, input bit jam, input bit rd,
                      input logic [15:0] ja, input logic [15:0] ev, input logic [15:0] al);
    bit er;
    @(negedge clk);
    reset              = rs;
    stall              = st;
    halt               = hl;
    jump_pred          = jp;
    jump_pred_miss     = jm;
    jump_pred_adr_miss = jam;
    imem_ready         = rd;
    jump_pred_adr      = ja;
    pcinc_evac         = ev;
    ALUres_mem         = al;
    imem_rdata         = 16'($urandom);
    #1;
    er = model_req();
    chk("imem_req", 32'(imem_req), 32'(er));
    chk("flush_id", 32'(flush_id), 32'(jm | jam));
    chk("flush_ex", 32'(flush_ex), 32'(jm | jam));
    if (m_known) chk("imem_adr_c", 32'(imem_adr), 32'(m_pc));
    @(posedge clk);
    model_update(er);
    #1;
    chk("imem_adr", 32'(imem_adr), 32'(m_pc));
    chk("instr_if", 32'(instr_if), 32'(m_instr));
    chk("pcinc_if", 32'(pcinc_if), 32'(m_pcinc));
    chk("valid_if", 32'(valid_if), 32'(m_valid));
    chk("pred_cnt", 32'(pred_cnt), 32'(m_pcnt));
    chk("miss_cnt", 32'(miss_cnt), 32'(m_mcnt));
  endtask

  task automatic run(input bit rd);
    step(0, 0, 0, 0, 0, 0, rd, 16'h0, 16'h0, 16'h0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; halt = 1'b0; jump_pred = 1'b0;
    jump_pred_miss = 1'b0; jump_pred_adr_miss = 1'b0; imem_ready = 1'b1;
    jump_pred_adr = 16'h0; pcinc_evac = 16'h0; ALUres_mem = 16'h0; imem_rdata = 16'h0;

    // Reset and sequential fetch.
    step(1, 0, 0, 0, 0, 0, 1, 16'h0, 16'h0, 16'h0);
    chk("rst_adr", 32'(imem_adr), 32'h0010);
    chk("rst_valid", 32'(valid_if), 32'h0);
    chk("rst_cnt", 32'({pred_cnt, miss_cnt}), 32'h0);
    run(1);
    chk("seq_pcinc", 32'(pcinc_if), 32'h0011);
    chk("seq_valid", 32'(valid_if), 32'h1);
    chk("seq_adr1", 32'(imem_adr), 32'h0011);
    run(1);
    chk("seq_adr2", 32'(imem_adr), 32'h0012);

    // Prediction: one bubble.
    step(0, 0, 0, 1, 0, 0, 1, 16'h0040, 16'h0, 16'h0);
    chk("pred_adr", 32'(imem_adr), 32'h0040);
    chk("pred_bubble", 32'(valid_if), 32'h0);
    chk("pred_cnt1", 32'(pred_cnt), 32'h1);
    run(1);
    chk("pred_pcinc", 32'(pcinc_if), 32'h0041);

    // Corrections, adr_miss winning over a simultaneous prediction.
    step(0, 0, 0, 1, 0, 1, 1, 16'h0777, 16'h0, 16'h0123);
    chk("corr_adr", 32'(imem_adr), 32'h0123);
    chk("corr_miss1", 32'(miss_cnt), 32'h1);
    chk("corr_pred1", 32'(pred_cnt), 32'h1);
    run(1);
    step(0, 0, 0, 0, 1, 0, 1, 16'h0, 16'h0051, 16'h0);
    chk("fall_adr", 32'(imem_adr), 32'h0051);
    chk("fall_miss2", 32'(miss_cnt), 32'h2);

    // Correction while a fetch is outstanding.
    run(0);
    step(0, 0, 0, 0, 0, 1, 0, 16'h0, 16'h0, 16'h0200);
    chk("drain_hold_adr", 32'(imem_adr), 32'h0051);
    run(0);
    run(1);
    chk("drain_adr", 32'(imem_adr), 32'h0200);
    chk("drain_no_stale", 32'(valid_if), 32'h0);
    run(1);
    chk("drain_pcinc", 32'(pcinc_if), 32'h0201);

    // PC wrap, then stall over a completing fetch.
    step(0, 0, 0, 1, 0, 0, 1, 16'hFFFF, 16'h0, 16'h0);
    run(1);
    chk("wrap_adr", 32'(imem_adr), 32'h0000);
    chk("wrap_pcinc", 32'(pcinc_if), 32'h0000);
    run(0);
    step(0, 1, 0, 0, 0, 0, 1, 16'h0, 16'h0, 16'h0);
    step(0, 1, 0, 0, 0, 0, 1, 16'h0, 16'h0, 16'h0);
    run(1);
    chk("hold_pcinc", 32'(pcinc_if), 32'h0001);
    chk("hold_valid", 32'(valid_if), 32'h1);
    run(1);
    chk("hold_next", 32'(pcinc_if), 32'h0002);

    // Halt sticks until reset.
    step(0, 0, 1, 0, 0, 0, 1, 16'h0, 16'h0, 16'h0);
    run(1);
    run(1);
    chk("halt_req", 32'(imem_req), 32'h0);
    chk("halt_valid", 32'(valid_if), 32'h0);
    step(1, 0, 0, 0, 0, 0, 1, 16'h0, 16'h0, 16'h0);
    chk("restart_adr", 32'(imem_adr), 32'h0010);
    run(1);
    chk("restart_pcinc", 32'(pcinc_if), 32'h0011);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(99) == 0, $urandom_range(3) == 0, $urandom_range(299) == 0,
           $urandom_range(7) == 0, $urandom_range(15) == 0, $urandom_range(15) == 0,
           $urandom_range(3) != 0, 16'($urandom), 16'($urandom), 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
